// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: counts MM:SS.CC in BCD from a 1 kHz tick.
// A prescaler divides i_tick down to centiseconds; the BCD digits ripple
// in a single edge. FSM: IDLE -> RUN <-> PAUSE, RUN -> FULL at 59:59.99.
// i_clear overrides everything and returns to IDLE with zeroed time.
// dbg_state exposes the FSM state for checkers (IDLE=0, RUN=1, PAUSE=2, FULL=3).
module stopwatch_ctrl #(
  parameter int TICKS_PER_CS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_o,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_o,
  output logic [3:0] o_cs_t,
  output logic [3:0] o_cs_o,
  output logic       o_running,
  output logic       o_full,
  output logic [1:0] dbg_state
);

  localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_CS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    FULL  = 2'd3
  } state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [3:0]    min_t_q, min_o_q, sec_t_q, sec_o_q, cs_t_q, cs_o_q;

  logic [3:0]    n_min_t, n_min_o, n_sec_t, n_sec_o, n_cs_t, n_cs_o;
  logic          adv_full;
  logic          wrap;

  // Prescaler reaches its last count on this tick: time advances this edge.
  assign wrap = i_tick && (presc_q == PRESC_MAX);

  // Next time value after a 0.01 s advance (BCD ripple carry).
  always_comb begin
    n_min_t = min_t_q;
    n_min_o = min_o_q;
    n_sec_t = sec_t_q;
    n_sec_o = sec_o_q;
    n_cs_t  = cs_t_q;
    n_cs_o  = cs_o_q;
    if (cs_o_q != 4'd9) begin
      n_cs_o = cs_o_q + 4'd1;
    end else begin
      n_cs_o = 4'd0;
      if (cs_t_q != 4'd9) begin
        n_cs_t = cs_t_q + 4'd1;
      end else begin
        n_cs_t = 4'd0;
        if (sec_o_q != 4'd9) begin
          n_sec_o = sec_o_q + 4'd1;
        end else begin
          n_sec_o = 4'd0;
          if (sec_t_q != 4'd5) begin
            n_sec_t = sec_t_q + 4'd1;
          end else begin
            n_sec_t = 4'd0;
            if (min_o_q != 4'd9) begin
              n_min_o = min_o_q + 4'd1;
            end else begin
              // min_t never passes 5: FULL stops counting at 59:59.99.
              n_min_o = 4'd0;
              n_min_t = min_t_q + 4'd1;
            end
          end
        end
      end
    end
    adv_full = ({n_min_t, n_min_o, n_sec_t, n_sec_o, n_cs_t, n_cs_o} == 24'h595999);
  end

  // FSM, prescaler and digit registers; clear dominates all other inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      min_t_q <= 4'd0;
      min_o_q <= 4'd0;
      sec_t_q <= 4'd0;
      sec_o_q <= 4'd0;
      cs_t_q  <= 4'd0;
      cs_o_q  <= 4'd0;
    end else if (i_clear) begin
      state_q <= IDLE;
      presc_q <= '0;
      min_t_q <= 4'd0;
      min_o_q <= 4'd0;
      sec_t_q <= 4'd0;
      sec_o_q <= 4'd0;
      cs_t_q  <= 4'd0;
      cs_o_q  <= 4'd0;
    end else begin
      case (state_q)
        // A tick arriving with start_stop in IDLE/PAUSE is not counted.
        IDLE, PAUSE: begin
          if (i_start_stop) state_q <= RUN;
        end
        RUN: begin
          if (i_tick) begin
            if (wrap) begin
              presc_q <= '0;
              min_t_q <= n_min_t;
              min_o_q <= n_min_o;
              sec_t_q <= n_sec_t;
              sec_o_q <= n_sec_o;
              cs_t_q  <= n_cs_t;
              cs_o_q  <= n_cs_o;
            end else begin
              presc_q <= presc_q + PW'(1);
            end
          end
          // Reaching the maximum takes priority over a coincident pause.
          if (wrap && adv_full) state_q <= FULL;
          else if (i_start_stop) state_q <= PAUSE;
        end
        FULL: begin
          state_q <= FULL;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_min_t   = min_t_q;
  assign o_min_o   = min_o_q;
  assign o_sec_t   = sec_t_q;
  assign o_sec_o   = sec_o_q;
  assign o_cs_t    = cs_t_q;
  assign o_cs_o    = cs_o_q;
  assign o_running = (state_q == RUN);
  assign o_full    = (state_q == FULL);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: directed steps plus a short random run.
// A behavioural model (elapsed time held as an integer count of
// centiseconds) pushes the expected outputs per cycle into exp_q; they are
// popped and compared on the following falling edge.
module tb_stopwatch_ctrl;

  localparam int T      = 10;
  localparam int MAX_CS = 359999;
  localparam int W      = 26;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_FULL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_tick, i_start_stop, i_clear;
  logic [3:0] o_min_t, o_min_o, o_sec_t, o_sec_o, o_cs_t, o_cs_o;
  logic       o_running, o_full;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;

  int m_state, m_presc, m_cs;
  logic [3:0] p_min_t, p_min_o, p_sec_t, p_sec_o, p_cs_t, p_cs_o;

  stopwatch_ctrl #(.TICKS_PER_CS(T)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_start_stop(i_start_stop),
    .i_clear(i_clear), .o_min_t(o_min_t), .o_min_o(o_min_o),
    .o_sec_t(o_sec_t), .o_sec_o(o_sec_o), .o_cs_t(o_cs_t), .o_cs_o(o_cs_o),
    .o_running(o_running), .o_full(o_full), .dbg_state(dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  function automatic logic [W-1:0] obs_vec();
    return {o_running, o_full, o_min_t, o_min_o, o_sec_t, o_sec_o, o_cs_t, o_cs_o};
  endfunction

  function automatic logic [W-1:0] exp_vec();
    int mn, sc, c;
    mn = m_cs / 6000;
    sc = (m_cs / 100) % 60;
    c  = m_cs % 100;
    return {(m_state == M_RUN), (m_state == M_FULL),
            4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_presc = 0;
    m_cs    = 0;
  endtask

  task automatic model_update(input logic tick, input logic ss, input logic clr);
    if (clr) begin
      model_reset();
    end else begin
      case (m_state)
        M_IDLE, M_PAUSE: if (ss) m_state = M_RUN;
        M_RUN: begin
          if (tick) begin
            if (m_presc == T - 1) begin
              m_presc = 0;
              m_cs++;
            end else begin
              m_presc++;
            end
          end
          if (m_cs == MAX_CS) m_state = M_FULL;
          else if (ss) m_state = M_PAUSE;
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive at the falling edge, compare at the next falling edge.
  task automatic step(input logic tick, input logic ss, input logic clr, input string tag);
    i_tick = tick;
    i_start_stop = ss;
    i_clear = clr;
    model_update(tick, ss, clr);
    exp_q.push_back(exp_vec());
    @(negedge clk);
    i_tick = 1'b0;
    i_start_stop = 1'b0;
    i_clear = 1'b0;
    check(tag, obs_vec(), exp_q.pop_front());
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, tag);
  endtask

  // Load a time into the digit registers while RUN with prescaler at 0.
  task automatic preload(input int cs);
    int mn, sc, c;
    mn = cs / 6000;
    sc = (cs / 100) % 60;
    c  = cs % 100;
    p_min_t = 4'(mn / 10);
    p_min_o = 4'(mn % 10);
    p_sec_t = 4'(sc / 10);
    p_sec_o = 4'(sc % 10);
    p_cs_t  = 4'(c / 10);
    p_cs_o  = 4'(c % 10);
    force dut.min_t_q = p_min_t;
    force dut.min_o_q = p_min_o;
    force dut.sec_t_q = p_sec_t;
    force dut.sec_o_q = p_sec_o;
    force dut.cs_t_q  = p_cs_t;
    force dut.cs_o_q  = p_cs_o;
    #1;
    release dut.min_t_q;
    release dut.min_o_q;
    release dut.sec_t_q;
    release dut.sec_o_q;
    release dut.cs_t_q;
    release dut.cs_o_q;
    m_cs = cs;
    check("preload", obs_vec(), exp_vec());
  endtask

  initial begin
    logic t, s, c;
    rst = 1'b0;
    i_tick = 1'b0;
    i_start_stop = 1'b0;
    i_clear = 1'b0;
    model_reset();
    #1;
    check("reset_state", obs_vec(), exp_vec());
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle ignores ticks; start; first centisecond; one second.
    ticks(3, "idle_tick");
    step(1'b0, 1'b1, 1'b0, "start");
    ticks(10, "first_cs");
    check("at_00_00_01", obs_vec(), {1'b1, 1'b0, 24'h000001});
    ticks(990, "to_1s");
    check("at_00_01_00", obs_vec(), {1'b1, 1'b0, 24'h000100});

    // Prescaler retained across pause.
    step(1'b0, 1'b0, 1'b1, "clear");
    step(1'b0, 1'b1, 1'b0, "start");
    ticks(7, "pre_pause");
    step(1'b0, 1'b1, 1'b0, "pause");
    ticks(20, "paused_ticks");
    step(1'b0, 1'b1, 1'b0, "resume");
    ticks(3, "post_resume");
    check("pause_retain", obs_vec(), {1'b1, 1'b0, 24'h000001});

    // Seconds-tens carry into minutes.
    step(1'b0, 1'b0, 1'b1, "clear");
    step(1'b0, 1'b1, 1'b0, "start");
    preload(5998);
    ticks(10, "to_59_99");
    ticks(10, "to_1min");
    check("at_01_00_00", obs_vec(), {1'b1, 1'b0, 24'h010000});

    // Reaching FULL and staying there.
    step(1'b0, 1'b0, 1'b1, "clear");
    step(1'b0, 1'b1, 1'b0, "start");
    preload(MAX_CS - 1);
    ticks(9, "near_full");
    step(1'b1, 1'b1, 1'b0, "full_with_ss");
    check("full_reached", obs_vec(), {1'b0, 1'b1, 24'h595999});
    ticks(15, "full_ticks");
    step(1'b0, 1'b1, 1'b0, "full_ss");
    step(1'b1, 1'b1, 1'b0, "full_ss_tick");
    step(1'b1, 1'b0, 1'b1, "full_clear_tick");
    check("full_cleared", obs_vec(), {1'b0, 1'b0, 24'h000000});

    // Clear beats start_stop and tick; prescaler zeroed by clear.
    step(1'b0, 1'b1, 1'b0, "start");
    ticks(5, "partial");
    step(1'b1, 1'b1, 1'b1, "clear_all");
    step(1'b0, 1'b1, 1'b0, "start");
    ticks(10, "after_clear");
    check("clear_presc", obs_vec(), {1'b1, 1'b0, 24'h000002 - 24'h000001});

    // Tick+start_stop: counted in RUN, not counted in PAUSE.
    step(1'b0, 1'b0, 1'b1, "clear");
    step(1'b0, 1'b1, 1'b0, "start");
    ticks(4, "pre_combo");
    step(1'b1, 1'b1, 1'b0, "run_tick_ss");
    step(1'b1, 1'b1, 1'b0, "pause_tick_ss");
    ticks(5, "post_combo");
    check("combo_count", obs_vec(), {1'b1, 1'b0, 24'h000001});

    // Random activity.
    for (int i = 0; i < 400; i++) begin
      t = ($urandom_range(0, 99) < 70);
      s = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 99) == 0);
      step(t, s, c, "random");
    end

    // Asynchronous reset mid-run at 00:03.47.
    step(1'b0, 1'b0, 1'b1, "clear");
    step(1'b0, 1'b1, 1'b0, "start");
    preload(346);
    ticks(10, "to_3_47");
    check("at_00_03_47", obs_vec(), {1'b1, 1'b0, 24'h000347});
    ticks(3, "partial_347");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_reset", obs_vec(), exp_vec());
    @(negedge clk);
    rst = 1'b1;
    ticks(5, "idle_after_reset");
    step(1'b0, 1'b1, 1'b0, "start");
    ticks(10, "reset_presc");
    check("reset_presc_cleared", obs_vec(), {1'b1, 1'b0, 24'h000001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_CS, default 10, the number of i_tick pulses per centisecond (range 1..1023).
REQ-002 SHALL have port clk  in  1  system clock (50 MHz); all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_tick  in  1  1 kHz single-cycle tick from the clock divider, synchronous to clk.
REQ-005 SHALL have port i_start_stop  in  1  single-cycle pulse that toggles run/pause.
REQ-006 SHALL have port i_clear  in  1  single-cycle pulse that zeroes the time and returns to idle.
REQ-007 SHALL have ports o_min_t, o_min_o, o_sec_t, o_sec_o, o_cs_t, o_cs_o  out  4 each  BCD minutes, seconds and centiseconds (tens and ones digits).
REQ-008 SHALL have port o_running  out  1  high while in RUN.
REQ-009 SHALL have port o_full  out  1  high while in FULL (59:59.99 reached).

Function
REQ-010 SHALL implement FSM states IDLE, RUN, PAUSE, FULL; encoding free.
REQ-011 Transitions SHALL be: IDLE + start_stop -> RUN; RUN + start_stop -> PAUSE; PAUSE + start_stop -> RUN; RUN + time reaching 59:59.99 -> FULL; any state + i_clear -> IDLE.
REQ-012 FULL SHALL ignore i_start_stop and i_tick; only i_clear or reset leaves it.
REQ-013 SHALL hold a prescaler of width clog2(TICKS_PER_CS), or 1 bit minimum, that increments on i_tick only in RUN.
REQ-014 Prescaler SHALL wrap from TICKS_PER_CS-1 to 0 and, in that same edge, advance time by 0.01 s.
REQ-015 Time advance SHALL be BCD ripple, all in one edge: cs_o 9->0 carries to cs_t; cs_t 9->0 to sec_o; sec_o 9->0 to sec_t; sec_t 5->0 to min_o; min_o 9->0 to min_t; min_t max 5.
REQ-016 When an advance produces 59:59.99, the state SHALL become FULL on that same edge, with the digits holding 59:59.99.
REQ-017 Digits SHALL never hold non-BCD values, and sec_t and min_t SHALL never exceed 5.
REQ-018 PAUSE SHALL retain both the digits and the prescaler; RUN resumes counting from the retained prescaler value.
REQ-019 i_clear SHALL zero the digits and the prescaler and enter IDLE at the next edge, in any state.
REQ-020 Simultaneous i_clear and i_start_stop: i_clear SHALL win (result IDLE, zeroed).
REQ-021 Simultaneous i_clear and i_tick: i_clear SHALL win; the tick is discarded.
REQ-022 Simultaneous i_tick and i_start_stop in RUN: the tick SHALL be counted and the state goes to PAUSE.
REQ-023 Simultaneous i_tick and i_start_stop in IDLE or PAUSE: the tick SHALL NOT be counted and the state goes to RUN.
REQ-024 o_running and o_full SHALL be registered, or decoded directly from the state register, and equal (state==RUN) and (state==FULL) respectively.
REQ-025 Latency: digit outputs SHALL update on the same clk edge that samples the qualifying i_tick; there SHALL be no extra pipeline stage.
REQ-026 Inputs held high for several cycles SHALL be treated as one event per high cycle; edge detection is not this block's responsibility.

Reset
REQ-027 Asserting rst low SHALL immediately, without waiting for clk, force: state IDLE, prescaler 0, all digits 0, o_running 0, o_full 0.
REQ-028 Reset asserted mid-RUN SHALL discard the partial prescaler count; after release the block stays in IDLE until i_start_stop.
REQ-029 Release of rst SHALL be treated as synchronous to clk by the integrator; the block adds no reset synchronizer.

Verification
REQ-030 Reset then start_stop, then 10 ticks (TICKS_PER_CS=10) -> digits 00:00.01, o_running=1; after 1000 ticks total -> 00:01.00.
REQ-031 Run to 00:59.99, then 10 ticks -> 01:00.00 (sec_t 5->0 carry into min_o).
REQ-032 Run to 7 ticks, start_stop, 20 ticks while paused, start_stop, 3 ticks -> 00:00.01, so the prescaler is retained across pause.
REQ-033 Preload run to 59:59.98, 10 ticks -> 59:59.99 with o_full=1 and o_running=0; further ticks and start_stop leave 59:59.99; clear -> 00:00.00, IDLE.
REQ-034 In RUN, i_clear together with i_start_stop and i_tick in one cycle -> IDLE, 00:00.00, prescaler 0; i_start_stop together with i_tick in RUN -> tick counted, PAUSE.
REQ-035 Drive rst low asynchronously between clk edges mid-RUN at 00:03.47 -> outputs 0 before the next clk edge; after release, ticks leave 00:00.00 until start_stop.
